cpld_link_peer: RTL and testbench

- Right-hand peer of the two-CPLD ball/position game. It consumes the 5-bit neighbour link that the left CPLD drives toward it and drives the 5-bit return link back.
- Owns the ball while it is on its own NCOL columns, handles the player's right-edge hit, and hands the ball back leftward.
- Generates its own column position and scan-select outputs for the local LED matrix.

---
 rtl/cpld_link_peer_if.sv | 26 ++
 rtl/cpld_link_peer.sv | 190 +++++++++++++++++++
 tb/tb_cpld_link_peer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cpld_link_peer_if.sv
// Signal bundle between the right-hand game CPLD and its surroundings:
// the 5-bit neighbour link in both directions, the two player buttons
// and the LED-matrix / status outputs.
interface cpld_link_peer_if;
    logic [4:0] link_in;
    logic [4:0] link_out;
    logic       rightbutton;
    logic       leftbutton;
    logic [2:0] pos_c;
    logic [2:0] sel;
    logic       active;
    logic       miss;
    logic [2:0] rally;

    // Environment side: drives the link word and the buttons.
    modport master (
        output link_in, rightbutton, leftbutton,
        input  link_out, pos_c, sel, active, miss, rally
    );

    // Peer CPLD side.
    modport slave (
        input  link_in, rightbutton, leftbutton,
        output link_out, pos_c, sel, active, miss, rally
    );
endinterface

// File: rtl/cpld_link_peer.sv
// Right-hand peer of the two-CPLD ball game. Receives the ball over the
// toggle-framed neighbour link, walks it across its own columns, handles
// the right-edge hit, hands the ball back leftward and drives the local
// LED scan select.
module cpld_link_peer #(
    parameter int NCOL     = 8,
    parameter int STEP_DIV = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             resetbutton,
    cpld_link_peer_if.slave  bus
);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [2:0]    LAST_COL  = 3'(NCOL - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, OWN} state_t;

    // Synchronisers and edge-detect history.
    logic [4:0] link_s1, ls, ls_d;
    logic       rx_tgl;
    logic       rb_s1, rb_s2, rb_d;
    logic       lb_s1, lb_s2, lb_d;

    // Game state and its next-state values.
    state_t      state, state_n;
    logic [2:0]  col, col_n;
    logic        dir_right, dir_right_n;
    logic [2:0]  rally_q, rally_n;
    logic [SW-1:0] step_cnt, step_cnt_n;
    logic        hit, hit_n;
    logic [4:0]  link_q, link_n;
    logic        miss_n;

    // Registered outputs.
    logic        active_q, miss_q;
    logic [2:0]  pos_q;
    logic [PW-1:0] scan_cnt;
    logic [2:0]  sel_q;

    logic accept, rb_edge, lb_edge, step;

    // A word is taken only once it has been stable for two samples and
    // carries a toggle different from the last one consumed.
    assign accept  = (ls[4] != rx_tgl) && (ls == ls_d);
    assign rb_edge = rb_s2 & ~rb_d;
    assign lb_edge = lb_s2 & ~lb_d;
    assign step    = (state == OWN) && (step_cnt == STEP_LAST);

    // Synchronise the link word and buttons into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which is what makes the sync chains work.
    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            link_s1 <= '0;
            ls      <= '0;
            ls_d    <= '0;
            rx_tgl  <= 1'b0;
            rb_s1   <= 1'b0;
            rb_s2   <= 1'b0;
            rb_d    <= 1'b0;
            lb_s1   <= 1'b0;
            lb_s2   <= 1'b0;
            lb_d    <= 1'b0;
        end else begin
            link_s1 <= bus.link_in;
            ls      <= link_s1;
            ls_d    <= ls;
            if (accept) rx_tgl <= ls[4];
            rb_s1   <= bus.rightbutton;
            rb_s2   <= rb_s1;
            rb_d    <= rb_s2;
            lb_s1   <= bus.leftbutton;
            lb_s2   <= lb_s1;
            lb_d    <= lb_s2;
        end
    end

    // Next-state logic: ball entry, stepping, hit window, miss and handoff.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n     = state;
        col_n       = col;
        dir_right_n = dir_right;
        rally_n     = rally_q;
        step_cnt_n  = step_cnt;
        hit_n       = hit;
        link_n      = link_q;
        miss_n      = 1'b0;
        case (state)
            IDLE: begin
                hit_n = 1'b0;
                if (accept) begin
                    state_n     = OWN;
                    col_n       = 3'd0;
                    dir_right_n = 1'b1;
                    rally_n     = ls[2:0] + 3'd1;
                    step_cnt_n  = '0;
                end else if (lb_edge) begin
                    state_n     = OWN;
                    col_n       = LAST_COL;
                    dir_right_n = 1'b0;
                    rally_n     = 3'd0;
                    step_cnt_n  = '0;
                end
            end
            OWN: begin
                // A word arriving while we hold the ball is only consumed.
                if (step) begin
                    step_cnt_n = '0;
                    hit_n      = 1'b0;
                    if (dir_right) begin
                        if (col != LAST_COL) begin
                            col_n = col + 3'd1;
                        end else if (hit) begin
                            dir_right_n = 1'b0;
                            col_n       = LAST_COL - 3'd1;
                            rally_n     = rally_q + 3'd1;
                        end else begin
                            miss_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        if (col != 3'd0) begin
                            col_n = col - 3'd1;
                        end else begin
                            link_n  = {~link_q[4], 1'b0, rally_q};
                            state_n = IDLE;
                        end
                    end
                end else begin
                    step_cnt_n = step_cnt + 1'b1;
                    if (rb_edge && dir_right && (col == LAST_COL)) hit_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Game state register with outputs registered from next-state values.
    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            state     <= IDLE;
            col       <= 3'd0;
            dir_right <= 1'b0;
            rally_q   <= 3'd0;
            step_cnt  <= '0;
            hit       <= 1'b0;
            link_q    <= 5'd0;
            miss_q    <= 1'b0;
            active_q  <= 1'b0;
            pos_q     <= 3'd0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            dir_right <= dir_right_n;
            rally_q   <= rally_n;
            step_cnt  <= step_cnt_n;
            hit       <= hit_n;
            link_q    <= link_n;
            miss_q    <= miss_n;
            active_q  <= (state_n == OWN);
            pos_q     <= (state_n == OWN) ? col_n : 3'd0;
        end
    end

    // Free-running LED scan select: prescaler followed by a column wrap.
    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            scan_cnt <= '0;
            sel_q    <= 3'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel_q    <= (sel_q == LAST_COL) ? 3'd0 : sel_q + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign bus.link_out = link_q;
    assign bus.pos_c    = pos_q;
    assign bus.sel      = sel_q;
    assign bus.active   = active_q;
    assign bus.miss     = miss_q;
    assign bus.rally    = rally_q;
endmodule

// File: tb/tb_cpld_link_peer.sv
// Self-checking bench for cpld_link_peer. Expected ball paths are built as
// column lists from the game rules (each column held STEP_DIV cycles), the
// scan select from elapsed clock edges, and link_out from a handoff model.
module tb_cpld_link_peer;
    localparam int NCOL     = 8;
    localparam int STEP_DIV = 6;
    localparam int SCAN_DIV = 3;

    logic clk = 1'b0;
    logic resetbutton;

    cpld_link_peer_if bus ();

    cpld_link_peer #(
        .NCOL(NCOL), .STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .resetbutton(resetbutton),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Clock edges since reset release, for the scan-select expectation.
    int unsigned edges;
    always @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) edges <= 0;
        else              edges <= edges + 1;
    end

    logic [4:0] lo_exp;
    logic       rx_model;
    logic [2:0] rally_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("sel", 32'(bus.sel), 32'((edges / SCAN_DIV) % NCOL));
    endtask

    task automatic wait_active(input string tag, input int lo, input int hi, output bit ok);
        int n;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.active === 1'b1) begin
                n = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(n >= lo && n <= hi), 32'd1);
        ok = (n != 0);
    endtask

    // Called on the first sample where active is high.
    task automatic play(input bit go_right, input int hit_at, input bit press_early, input bit inject);
        int  path[$];
        bit  hit;
        bit  missed;
        hit    = go_right && (hit_at >= 0);
        missed = go_right && !hit;
        if (go_right) begin
            for (int c = 0; c < NCOL; c++) path.push_back(c);
            if (hit) for (int c = NCOL - 2; c >= 0; c--) path.push_back(c);
        end else begin
            for (int c = NCOL - 1; c >= 0; c--) path.push_back(c);
        end
        for (int p = 0; p < path.size(); p++) begin
            for (int s = 0; s < STEP_DIV; s++) begin
                if (!(p == 0 && s == 0)) tick();
                if (hit && p == NCOL && s == 0) rally_exp = rally_exp + 3'd1;
                check("active", 32'(bus.active), 32'd1);
                check("pos_c", 32'(bus.pos_c), 32'(path[p]));
                check("rally", 32'(bus.rally), 32'(rally_exp));
                check("miss_low", 32'(bus.miss), 32'd0);
                bus.rightbutton = (hit && p == NCOL - 1 && s == hit_at) ||
                                  (press_early && p == NCOL - 3 && s == 0);
                if (inject && p == 2 && s == 0) begin
                    rx_model    = ~rx_model;
                    bus.link_in = {rx_model, 1'b0, 3'($urandom_range(0, 7))};
                end
            end
        end
        tick();
        if (!missed) lo_exp = {~lo_exp[4], 1'b0, rally_exp};
        check("end_active", 32'(bus.active), 32'd0);
        check("end_pos_c", 32'(bus.pos_c), 32'd0);
        check("end_miss", 32'(bus.miss), 32'(missed));
        check("link_out", 32'(bus.link_out), 32'(lo_exp));
        check("rally_hold", 32'(bus.rally), 32'(rally_exp));
        tick();
        check("miss_one_cycle", 32'(bus.miss), 32'd0);
        check("still_idle", 32'(bus.active), 32'd0);
        bus.rightbutton = 1'b0;
    endtask

    task automatic send_word(output logic [2:0] r);
        r           = 3'($urandom_range(0, 7));
        rx_model    = ~rx_model;
        bus.link_in = {rx_model, 1'($urandom_range(0, 1)), r};
        rally_exp   = r + 3'd1;
    endtask

    initial begin
        logic [4:0] w;
        logic [2:0] r;
        bit ok;

        resetbutton     = 1'b0;
        bus.link_in     = 5'd0;
        bus.rightbutton = 1'b0;
        bus.leftbutton  = 1'b0;
        lo_exp    = 5'd0;
        rx_model  = 1'b0;
        rally_exp = 3'd0;

        // Reset state.
        repeat (3) tick();
        check("rst_link_out", 32'(bus.link_out), 32'd0);
        check("rst_pos_c", 32'(bus.pos_c), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_miss", 32'(bus.miss), 32'd0);
        check("rst_rally", 32'(bus.rally), 32'd0);
        resetbutton = 1'b1;

        // Received ball, returned with a hit, handed back left.
        repeat (4) tick();
        send_word(r);
        wait_active("acc_hit", 3, 4, ok);
        if (ok) play(1'b1, int'($urandom_range(0, 2)), 1'b0, 1'b0);

        // One-cycle glitch on the toggle bit must not accept.
        w = bus.link_in;
        bus.link_in = w ^ 5'b10000;
        tick();
        bus.link_in = w;
        repeat (10) begin
            tick();
            check("glitch_idle", 32'(bus.active), 32'd0);
        end

        // Same toggle with different payload must not accept.
        bus.link_in = {rx_model, 1'b0, 3'(w[2:0] + 3'd3)};
        repeat (10) begin
            tick();
            check("dup_idle", 32'(bus.active), 32'd0);
        end

        // Ball lost: no hit at the right edge.
        send_word(r);
        wait_active("acc_miss", 3, 4, ok);
        if (ok) play(1'b1, -1, 1'b0, 1'b0);

        // Ball lost: hit pressed too early (column NCOL-3).
        send_word(r);
        wait_active("acc_early", 3, 4, ok);
        if (ok) play(1'b1, -1, 1'b1, 1'b0);

        // Accept and serve edges land in the same cycle: accept wins.
        r           = 3'($urandom_range(0, 5));
        rx_model    = ~rx_model;
        bus.link_in = {rx_model, 1'b0, r};
        rally_exp   = r + 3'd1;
        tick();
        bus.leftbutton = 1'b1;
        tick();
        bus.leftbutton = 1'b0;
        wait_active("acc_vs_serve", 1, 2, ok);
        if (ok) play(1'b1, int'($urandom_range(0, 2)), 1'b0, 1'b0);

        // Reset in the middle of a served ball.
        bus.leftbutton = 1'b1;
        tick();
        bus.leftbutton = 1'b0;
        repeat (6) tick();
        resetbutton = 1'b0;
        bus.link_in = 5'd0;
        #1;
        check("mid_rst_link_out", 32'(bus.link_out), 32'd0);
        check("mid_rst_pos_c", 32'(bus.pos_c), 32'd0);
        check("mid_rst_sel", 32'(bus.sel), 32'd0);
        check("mid_rst_active", 32'(bus.active), 32'd0);
        check("mid_rst_miss", 32'(bus.miss), 32'd0);
        check("mid_rst_rally", 32'(bus.rally), 32'd0);
        lo_exp    = 5'd0;
        rx_model  = 1'b0;
        rally_exp = 3'd0;
        tick();
        resetbutton = 1'b1;
        repeat (3) tick();

        // Serve from the right edge; a word arriving mid-flight is consumed.
        bus.leftbutton = 1'b1;
        tick();
        bus.leftbutton = 1'b0;
        rally_exp = 3'd0;
        wait_active("serve", 1, 3, ok);
        if (ok) play(1'b0, -1, 1'b0, 1'b1);
        repeat (10) begin
            tick();
            check("consumed_idle", 32'(bus.active), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
